deck_dealer_ctrl: RTL

DECK_DEALER_CTRL -- requirements
Module: deck_dealer_ctrl

---
 rtl/deck_dealer_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/deck_dealer_ctrl.sv
// Card-deck controller: Fisher-Yates shuffle of an external 52x4 RAM driven by a 6-bit LFSR,
// then round-robin dealing of one card per two cycles to a player and a dealer.
module deck_dealer_ctrl #(
  parameter logic [5:0] SEED = 6'h2D
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       shuffle_start,
  input  logic [1:0] deal_req,
  output logic [1:0] deal_gnt,
  output logic [3:0] card_out,
  output logic       card_valid,
  output logic       busy,
  output logic       deck_empty,
  output logic [5:0] cards_left,
  output logic       ram_wr_en,
  output logic [5:0] ram_addr,
  output logic [3:0] ram_din,
  input  logic [3:0] ram_dout
);

  localparam logic [5:0] SEED_EFF = (SEED == 6'd0) ? 6'd1 : SEED;
  localparam logic [5:0] DECK     = 6'd52;
  localparam logic [5:0] LAST     = 6'd51;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] PICK  = 3'd1;
  localparam logic [2:0] RDI   = 3'd2;
  localparam logic [2:0] RDJ   = 3'd3;
  localparam logic [2:0] WRI   = 3'd4;
  localparam logic [2:0] WRJ   = 3'd5;
  localparam logic [2:0] READY = 3'd6;
  localparam logic [2:0] DEAL  = 3'd7;

  logic [2:0] state;
  logic [5:0] lfsr, i, j, ptr;
  logic [3:0] tmp_i;
  logic       prio;     // 0: player wins a tie, 1: dealer wins a tie
  logic [1:0] gnt;
  logic [5:0] pick_j;
  logic       can_deal;
  logic [1:0] gnt_nxt;

  assign pick_j   = lfsr - 6'd1;
  // A shuffle request in READY outranks any pending deal.
  assign can_deal = (state == READY) && (ptr < DECK) && (|deal_req) && !shuffle_start;

  always_comb begin
    gnt_nxt = deal_req;
    if (&deal_req) gnt_nxt = prio ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lfsr  <= SEED_EFF;
      ptr   <= DECK;
      i     <= LAST;
      j     <= 6'd0;
      tmp_i <= 4'd0;
      prio  <= 1'b0;
      gnt   <= 2'b00;
    end else begin
      lfsr <= {lfsr[4:0], lfsr[5] ^ lfsr[4]};
      case (state)
        IDLE, READY: begin
          if (shuffle_start) begin
            i     <= LAST;
            ptr   <= 6'd0;
            state <= PICK;
          end else if (can_deal) begin
            gnt   <= gnt_nxt;
            state <= DEAL;
          end
        end
        PICK: begin
          // Rejection sampling: retry on later LFSR values until j lands in 0..i.
          j <= pick_j;
          if (pick_j <= i) state <= RDI;
        end
        RDI: state <= RDJ;
        RDJ: begin
          tmp_i <= ram_dout;
          state <= WRI;
        end
        WRI: state <= WRJ;
        WRJ: begin
          if (i == 6'd1) state <= READY;
          else begin
            i     <= i - 6'd1;
            state <= PICK;
          end
        end
        DEAL: begin
          ptr   <= ptr + 6'd1;
          prio  <= gnt[0];
          gnt   <= 2'b00;
          state <= READY;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are forced to their reset values during rst so no RAM write can land in that cycle.
  always_comb begin
    deal_gnt   = 2'b00;
    card_out   = 4'd0;
    card_valid = 1'b0;
    busy       = 1'b0;
    deck_empty = 1'b1;
    cards_left = 6'd0;
    ram_wr_en  = 1'b0;
    ram_addr   = 6'd0;
    ram_din    = 4'd0;
    if (!rst) begin
      busy       = (state inside {PICK, RDI, RDJ, WRI, WRJ});
      deck_empty = (ptr == DECK);
      cards_left = DECK - ptr;
      case (state)
        RDI: ram_addr = i;
        RDJ: ram_addr = j;
        WRI: begin
          ram_wr_en = 1'b1;
          ram_addr  = i;
          ram_din   = ram_dout;
        end
        WRJ: begin
          ram_wr_en = 1'b1;
          ram_addr  = j;
          ram_din   = tmp_i;
        end
        READY: if (can_deal) ram_addr = ptr;
        DEAL: begin
          card_out   = ram_dout;
          card_valid = 1'b1;
          deal_gnt   = gnt;
        end
        default: ;
      endcase
    end
  end

endmodule
